// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared geometry, fill character and engine state encoding
// Purpose: constants for the 80x60 character RAM and the block-engine state enum,
//          imported by vram_fill_engine and vram_arbiter.
// Ports:   none (package).
package vram_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int AW    = 13;
    localparam int DW    = 7;
    localparam int CELLS = ROWS * COLS;

    localparam logic [DW-1:0] FILL = 7'h20;

    // Last cell overall, and last destination cell of the row-move phase of a scroll.
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_MOVE = AW'((ROWS - 1) * COLS - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_CLR,
        ENG_SCR_RD,
        ENG_SCR_WR,
        ENG_SCR_FILL
    } eng_state_e;

endpackage

// File: rtl/vram_fill_engine.sv
// rtl/vram_fill_engine.sv - block engine: screen clear and one-row scroll-up
// Purpose: walks the character RAM one cell per granted access. Clear writes FILL
//          everywhere; scroll copies cell ptr+COLS to ptr for all but the last row,
//          then fills the last row with FILL.
// Ports:   clk_i, clrn_i        clock, synchronous active-low reset
//          cmd_clear_i/_scroll_i start pulses (ignored while busy_o)
//          eng_gnt_i            access granted this cycle by the arbiter
//          ram_rdata_i          RAM read data (valid the cycle after a read grant)
//          eng_req_o/we_o/addr_o/wdata_o  access request towards the arbiter
//          busy_o               engine not idle
module vram_fill_engine
    import vram_pkg::*;
(
    input  logic          clk_i,
    input  logic          clrn_i,
    input  logic          cmd_clear_i,
    input  logic          cmd_scroll_i,
    input  logic          eng_gnt_i,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          eng_req_o,
    output logic          eng_we_o,
    output logic [AW-1:0] eng_addr_o,
    output logic [DW-1:0] eng_wdata_o,
    output logic          busy_o
);

    eng_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          rd_pend_q, rd_pend_d;

    always_ff @(posedge clk_i) begin
        if (!clrn_i) begin
            state_q   <= ENG_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        rd_pend_d   = 1'b0;
        eng_req_o   = 1'b0;
        eng_we_o    = 1'b0;
        eng_addr_o  = ptr_q;
        eng_wdata_o = FILL;

        // Read data is only on the bus for one cycle, so it is captured
        // unconditionally even if the following write is stalled.
        if (rd_pend_q) begin
            hold_d = ram_rdata_i;
        end

        unique case (state_q)
            ENG_IDLE: begin
                if (cmd_clear_i) begin
                    state_d = ENG_CLR;
                    ptr_d   = '0;
                end else if (cmd_scroll_i) begin
                    state_d = ENG_SCR_RD;
                    ptr_d   = '0;
                end
            end
            ENG_CLR, ENG_SCR_FILL: begin
                eng_req_o = 1'b1;
                eng_we_o  = 1'b1;
                if (eng_gnt_i) begin
                    if (ptr_q == LAST_CELL) begin
                        state_d = ENG_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            ENG_SCR_RD: begin
                eng_req_o  = 1'b1;
                eng_addr_o = ptr_q + ROW_STEP;
                if (eng_gnt_i) begin
                    rd_pend_d = 1'b1;
                    state_d   = ENG_SCR_WR;
                end
            end
            ENG_SCR_WR: begin
                eng_req_o   = 1'b1;
                eng_we_o    = 1'b1;
                // A write granted in the capture cycle takes the data straight
                // from the RAM, so an uncontended move costs two cycles.
                eng_wdata_o = rd_pend_q ? ram_rdata_i : hold_q;
                if (eng_gnt_i) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = (ptr_q == LAST_MOVE) ? ENG_SCR_FILL : ENG_SCR_RD;
                end
            end
            default: begin
                state_d = ENG_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != ENG_IDLE);

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port character RAM arbiter (VGA > CPU > block engine)
// Purpose: one RAM access per cycle with fixed priority; steers registered-read
//          data back to the VGA and CPU ports and hosts the block engine.
// Ports:   clk_sys, clrn                 clock, synchronous active-low reset
//          vga_req/vga_addr -> vga_data/vga_valid    scan-out reads, 1-cycle latency
//          cpu_req/we/addr/wdata -> cpu_rdata/cpu_ack  loads and stores
//          cmd_clear/cmd_scroll -> busy  block engine control
//          ram_addr/ram_we/ram_wdata, ram_rdata   RAM port (1-cycle read latency)
module vram_arbiter
    import vram_pkg::*;
(
    input  logic          clk_sys,
    input  logic          clrn,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,
    output logic          vga_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          cmd_clear,
    input  logic          cmd_scroll,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    logic          vga_gnt, cpu_gnt, eng_gnt;
    logic          eng_req, eng_we;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;

    logic          vga_pend_q, cpu_pend_q, cpu_load_q;
    logic [DW-1:0] vga_hold_q, vga_hold_d;
    logic [DW-1:0] cpu_hold_q, cpu_hold_d;

    vram_fill_engine u_engine (
        .clk_i        (clk_sys),
        .clrn_i       (clrn),
        .cmd_clear_i  (cmd_clear),
        .cmd_scroll_i (cmd_scroll),
        .eng_gnt_i    (eng_gnt),
        .ram_rdata_i  (ram_rdata),
        .eng_req_o    (eng_req),
        .eng_we_o     (eng_we),
        .eng_addr_o   (eng_addr),
        .eng_wdata_o  (eng_wdata),
        .busy_o       (busy)
    );

    // No grants while in reset keeps the RAM port quiet during clrn=0.
    // cpu_pend_q blocks re-granting a request in its own ack cycle.
    assign vga_gnt = clrn & vga_req;
    assign cpu_gnt = clrn & cpu_req & ~vga_req & ~cpu_pend_q;
    assign eng_gnt = clrn & eng_req & ~vga_req & ~cpu_gnt;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (vga_gnt) begin
            ram_addr = vga_addr;
        end else if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_we ? cpu_wdata : '0;
        end else if (eng_gnt) begin
            ram_addr  = eng_addr;
            ram_we    = eng_we;
            ram_wdata = eng_we ? eng_wdata : '0;
        end
    end

    // Returned data is presented in the cycle the RAM delivers it and held after.
    assign vga_hold_d = vga_pend_q ? ram_rdata : vga_hold_q;
    assign cpu_hold_d = (cpu_pend_q & cpu_load_q) ? ram_rdata : cpu_hold_q;

    always_ff @(posedge clk_sys) begin
        if (!clrn) begin
            vga_pend_q <= 1'b0;
            cpu_pend_q <= 1'b0;
            cpu_load_q <= 1'b0;
            vga_hold_q <= '0;
            cpu_hold_q <= '0;
        end else begin
            vga_pend_q <= vga_gnt;
            cpu_pend_q <= cpu_gnt;
            cpu_load_q <= cpu_gnt & ~cpu_we;
            vga_hold_q <= vga_hold_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign vga_data  = vga_hold_d;
    assign vga_valid = vga_pend_q;
    assign cpu_rdata = cpu_hold_d;
    assign cpu_ack   = cpu_pend_q;

endmodule
